// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle multiply/divide unit owning the HI/LO register pair of a
// single-cycle MIPS datapath. MULTU/DIVU run one bit per clock (shift-add
// multiply, restoring divide) in working registers kept apart from the
// committed HI/LO, so HI/LO only ever change all at once. MTHI/MTLO write the
// committed registers directly from IDLE. A combinational stall freezes the
// datapath while a HI/LO consumer or a new mul/div has to wait.
//
// Optional build macro: MULDIV_SIGNED_EN
//   defined   : adds i_signed_op (MULT/DIV), magnitude conversion at start and a
//               FIX state that applies result signs; latency WIDTH+1 for all ops.
//   undefined : unsigned only, latency WIDTH.
//
// Ports
//   i_clk        in   1      clock, rising edge
//   i_reset      in   1      asynchronous active-high reset, clears all state
//   i_start      in   1      request, qualified by i_op, sampled only in IDLE
//   i_op         in   2      00 MULTU, 01 DIVU, 10 MTLO, 11 MTHI
//   i_opa        in   WIDTH  multiplicand / dividend / MTxx data
//   i_opb        in   WIDTH  multiplier / divisor
//   i_signed_op  in   1      (MULDIV_SIGNED_EN only) signed MULT/DIV
//   i_hilo_rd    in   1      datapath executes MFHI/MFLO this cycle
//   i_flush      in   1      synchronous abort of an in-flight operation
//   o_hi         out  WIDTH  committed HI
//   o_lo         out  WIDTH  committed LO
//   o_busy       out  1      operation in flight
//   o_done       out  1      one-cycle completion pulse
//   o_stall      out  1      freeze datapath PC/writeback this cycle
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
`ifdef MULDIV_SIGNED_EN
    input  logic             i_signed_op,
`endif
    input  logic             i_hilo_rd,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTLO  = 2'b10;
    localparam logic [1:0] OP_MTHI  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DONE = 3'd3
`ifdef MULDIV_SIGNED_EN
        , S_FIX = 3'd4
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // MUL: product/multiplier; DIV: low half = dividend/quotient
    logic [WIDTH:0]     r_rem;     // DIV partial remainder
    logic [WIDTH-1:0]   r_opb;     // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_load;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc_nxt;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH:0]     w_div_rem_nxt;
    logic [WIDTH-1:0]   w_div_q_nxt;
    logic [WIDTH-1:0]   w_opa_mag;
    logic [WIDTH-1:0]   w_opb_mag;

    // A request is only taken in IDLE, and a concurrent flush suppresses it.
    assign w_accept = i_start & ~i_flush & (r_state == S_IDLE);
    assign w_load   = w_accept & ((i_op == OP_MULTU) | (i_op == OP_DIVU));
    assign w_last   = (r_cnt == CNT_LAST);

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;   // product / quotient must be negated
    logic r_neg_r;   // remainder must be negated (dividend was negative)
    logic r_is_div;

    assign w_opa_mag = (i_signed_op & i_opa[WIDTH-1]) ? (~i_opa + {{(WIDTH-1){1'b0}}, 1'b1}) : i_opa;
    assign w_opb_mag = (i_signed_op & i_opb[WIDTH-1]) ? (~i_opb + {{(WIDTH-1){1'b0}}, 1'b1}) : i_opb;
`else
    assign w_opa_mag = i_opa;
    assign w_opb_mag = i_opb;
`endif

    // Shift-add step: the low half starts as one operand and is scanned LSB
    // first; the carry of the upper-half add re-enters at the top on the shift.
    assign w_mul_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                         + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step. A set top remainder bit (only reachable when dividing by
    // zero) means the partial remainder already exceeds any divisor.
    assign w_div_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_div_ge      = r_rem[WIDTH] | (w_div_shift >= {1'b0, r_opb});
    assign w_div_rem_nxt = w_div_ge ? (w_div_shift - {1'b0, r_opb}) : w_div_shift;
    assign w_div_q_nxt   = {r_acc[WIDTH-2:0], w_div_ge};

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (i_op == OP_MULTU)) begin
                    w_state_nxt = S_MUL;
                end else if (w_accept && (i_op == OP_DIVU)) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
`ifdef MULDIV_SIGNED_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered busy/done flags, derived from the state being entered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_MUL) | (w_state_nxt == S_DIV)
`ifdef MULDIV_SIGNED_EN
                    | (w_state_nxt == S_FIX)
`endif
                    ;
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Iteration counter and working registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= {CW{1'b0}};
            r_acc <= {(2*WIDTH){1'b0}};
            r_rem <= {(WIDTH+1){1'b0}};
            r_opb <= {WIDTH{1'b0}};
        end else if (w_load) begin
            r_cnt <= {CW{1'b0}};
            r_acc <= {{WIDTH{1'b0}}, w_opa_mag};
            r_rem <= {(WIDTH+1){1'b0}};
            r_opb <= w_opb_mag;
        end else if ((r_state == S_MUL) && !i_flush) begin
            r_acc <= w_mul_acc_nxt;
            r_cnt <= w_last ? r_cnt : (r_cnt + CNT_ONE);
        end else if ((r_state == S_DIV) && !i_flush) begin
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_div_q_nxt};
            r_rem <= w_div_rem_nxt;
            r_cnt <= w_last ? r_cnt : (r_cnt + CNT_ONE);
        end
    end

`ifdef MULDIV_SIGNED_EN
    // Sign bookkeeping captured with the operands.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
        end else if (w_load) begin
            r_neg_q  <= i_signed_op & (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
            r_neg_r  <= i_signed_op & i_opa[WIDTH-1];
            r_is_div <= (i_op == OP_DIVU);
        end
    end
`endif

    // Committed HI/LO: MTxx writes from IDLE, whole-result commit at completion.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
        end else if (w_accept && (i_op == OP_MTLO)) begin
            r_lo <= i_opa;
        end else if (w_accept && (i_op == OP_MTHI)) begin
            r_hi <= i_opa;
`ifdef MULDIV_SIGNED_EN
        end else if ((r_state == S_FIX) && !i_flush) begin
            if (r_is_div) begin
                r_lo <= r_neg_q ? (~r_acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc[WIDTH-1:0];
                r_hi <= r_neg_r ? (~r_rem[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : r_rem[WIDTH-1:0];
            end else begin
                {r_hi, r_lo} <= r_neg_q ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;
            end
`else
        end else if ((r_state == S_MUL) && !i_flush && w_last) begin
            {r_hi, r_lo} <= w_mul_acc_nxt;
        end else if ((r_state == S_DIV) && !i_flush && w_last) begin
            r_lo <= w_div_q_nxt;
            r_hi <= w_div_rem_nxt[WIDTH-1:0];
`endif
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    // Stall is combinational so the requesting instruction is held in the same cycle.
    assign o_stall = r_busy & (i_hilo_rd | i_start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Scoreboard bench for muldiv_sequencer: the stimulus process pushes the
// expected {HI,LO} of every mul/div it issues; a monitor pops and compares on
// each done pulse. Expected values come from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         hilo_rd;
    logic         flush;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;
`ifdef MULDIV_SIGNED_EN
    logic         s_op = 1'b0;
`endif

    logic [63:0]  exp_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    int           checks = 0;
    int           errors = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_op       (op),
        .i_opa      (opa),
        .i_opb      (opb),
`ifdef MULDIV_SIGNED_EN
        .i_signed_op(s_op),
`endif
        .i_hilo_rd  (hilo_rd),
        .i_flush    (flush),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_busy     (busy),
        .o_done     (done),
        .o_stall    (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI,LO} result of MULTU/DIVU from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] r;
        if (o == 2'b00) begin
            r = 64'(a) * 64'(b);
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("hilo_at_done", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Issue one operation and follow it to completion (or flush).
    // rd_mode: 0 hilo_rd low, 1 random, 2 held high. hold: keep a DIVU 9/3 start asserted.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] e, input int flush_at, input int rd_mode, input bit hold);
        int  n;
        bit  got_done;
        bit  flushed;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        if (o[1]) begin
            @(negedge clk);
            start = 1'b0;
            if (o == 2'b10) m_lo = a; else m_hi = a;
            #1;
            check("mt_hilo", {hi, lo}, {m_hi, m_lo});
            check("mt_busy", busy, 1'b0);
            check("mt_done", done, 1'b0);
            return;
        end
        if (flush_at < 0) exp_q.push_back(e);
        @(negedge clk);
        start = hold;
        if (hold) begin
            op = 2'b01; opa = 32'd9; opb = 32'd3;
        end
        n = 0; got_done = 1'b0; flushed = 1'b0;
        for (int c = 0; c < LAT + 10; c++) begin
            hilo_rd = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (done) begin
                got_done = 1'b1;
                check("stall_in_done", stall, 1'b0);
                break;
            end
            if (!busy) break;
            n++;
            check("stall_busy", stall, hilo_rd | start);
            if (n == flush_at) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                #1;
                check("flush_busy", busy, 1'b0);
                check("flush_done", done, 1'b0);
                check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});
                flushed = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        hilo_rd = 1'b0;
        if (!flushed) begin
            check("done_seen", got_done, 1'b1);
            check("busy_cycles", n, LAT);
            m_hi = e[63:32];
            m_lo = e[31:0];
            @(negedge clk);
            #1;
            check("done_single_pulse", done, 1'b0);
            check("idle_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        int          n;
        bit          seen;
        logic [1:0]  ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int          fl;

        rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        hilo_rd = 1'b0; flush = 1'b0; m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_stall", stall, 1'b0);
        rst = 1'b0;

        // Directed cases with constants taken straight from the arithmetic.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, 0, 1'b0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b01, 32'd100, 32'd7, {32'd2, 32'd14}, -1, 0, 1'b0);
        check("divu_100_7", {hi, lo}, {32'h2, 32'hE});
        run_op(2'b01, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, -1, 0, 1'b0);
        check("divu_by_zero", {hi, lo}, {32'h5, 32'hFFFF_FFFF});

        run_op(2'b10, 32'h1234, 32'd0, 64'd0, -1, 0, 1'b0);
        run_op(2'b11, 32'hABCD, 32'd0, 64'd0, -1, 0, 1'b0);
        check("mt_values", {hi, lo}, {32'hABCD, 32'h1234});
        run_op(2'b00, 32'd3, 32'd4, 64'd12, 10, 0, 1'b0);
        check("flush_retains", {hi, lo}, {32'hABCD, 32'h1234});

        // MFxx waiting plus a second start held through the whole operation.
        run_op(2'b00, 32'd6, 32'd7, 64'd42, -1, 2, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("second_start_ignored_busy", busy, 1'b0);
        check("second_start_hilo", {hi, lo}, {32'd0, 32'h2A});

        // Asynchronous reset between edges during a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd1000; opb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            #1;
            if (busy) n++;
            if (n == 20) break;
            @(negedge clk);
        end
        check("busy_before_reset", n, 20);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("no_done_after_reset", seen, 1'b0);

        // Randomized mix of all four operations with occasional flushes.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = 32'($urandom);
            else rb = 32'($urandom_range(1, 300));
            fl = (!ro[1] && ($urandom_range(0, 4) == 0)) ? int'($urandom_range(1, LAT - 1)) : -1;
            run_op(ro, ra, rb, ref_model(ro, ra, rb), fl, 1, 1'b0);
            check("random_hilo_model", {hi, lo}, {m_hi, m_lo});
        end

`ifdef MULDIV_SIGNED_EN
        s_op = 1'b1;
        run_op(2'b00, 32'hFFFF_FFFA, 32'd7, 64'hFFFF_FFFF_FFFF_FFD6, -1, 0, 1'b0);
        check("mult_signed", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFD6});
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, 0, 1'b0);
        check("div_signed", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        s_op = 1'b0;
`endif

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair for the single-cycle MIPS datapath.
- Executes MULTU/DIVU iteratively, one bit per cycle, so the 32x32 product/quotient leaves the ALU critical path.
- Sequences the operation and raises stall toward the datapath while a HI/LO consumer or a new mul/div must wait.
- Also serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand width; also the iteration count per operation.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; qualified by op, sampled only in IDLE
- op  in  2  00 MULTU, 01 DIVU, 10 MTLO, 11 MTHI
- opa  in  WIDTH  multiplicand / dividend / MTxx data
- opb  in  WIDTH  multiplier / divisor
- hilo_rd  in  1  datapath is executing MFHI/MFLO this cycle
- flush  in  1  synchronous abort of an in-flight operation
- hi  out  WIDTH  committed HI
- lo  out  WIDTH  committed LO
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- stall  out  1  freeze datapath PC/writeback this cycle

Behaviour:
- Reset (async): state=IDLE; hi=0, lo=0, busy=0, done=0, iteration counter=0, working regs=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & op=00 -> load working regs, counter=0, go to MUL.
  - start & op=01 -> same setup, go to DIV.
  - start & op=10 -> lo<=opa at this edge; stay IDLE; no busy, no done.
  - start & op=11 -> hi<=opa at this edge; stay IDLE; no busy, no done.
- MUL: shift-add, one multiplier bit per edge; WIDTH iterations; 2*WIDTH-bit accumulator in working regs.
- DIV: restoring division, one quotient bit per edge; WIDTH iterations; remainder in a WIDTH+1-bit working reg.
- Commit at the edge of the last iteration; state goes to DONE.
  - MUL: hi = product[2W-1:W], lo = product[W-1:0].
  - DIV: lo = quotient, hi = remainder.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start sampled at edge N -> busy=1 after edges N..N+WIDTH-1 (WIDTH cycles) -> hi/lo valid and done=1 after edge N+WIDTH.
- hi/lo are never partially updated; working regs are separate from the committed regs.
- Divide by zero: no trap, no special path; the algorithm yields lo = all ones, hi = opa; normal latency.
- start while busy or in DONE: ignored, not queued; the datapath must hold it via stall.
- stall = busy & (hilo_rd | start), combinational. Stall is 0 in DONE, so a waiting MFxx reads committed hi/lo in the done cycle.
- flush in MUL/DIV: next edge state=IDLE, busy=0, hi/lo keep their previous committed values, no done pulse.
- flush in IDLE/DONE: no effect.
- flush and start in the same cycle: flush wins; start ignored.
- reset mid-operation: immediate IDLE with hi=lo=0; no done pulse.
- All arithmetic is unsigned and modulo the stated widths; the counter wraps only through reload in IDLE.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Extra input port signed_op (1 bit), sampled with start, selects MULT/DIV.
  - Operands are converted to magnitudes at start.
  - Added state FIX between the last iteration and DONE negates the results: product if the operand signs differ; quotient likewise; remainder takes the dividend sign.
  - Latency is WIDTH+1 for both signed and unsigned operations, so timing stays uniform.
- Undefined: no signed_op port, no FIX state, unsigned only, latency WIDTH.

Test Plan:
- Reset, MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done pulse once, hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> done after 32 cycles, lo=0x0000000E, hi=0x00000002. DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005.
- MTLO 0x1234 then MTHI 0xABCD -> lo=0x1234, hi=0xABCD next cycle, busy=0, done=0. Then MULTU 3*4 with flush at iteration 10 -> IDLE next edge, lo=0x1234, hi=0xABCD retained.
- MULTU 6*7 with hilo_rd=1 and a second start (DIVU 9/3) held during busy -> stall=1 every busy cycle, stall=0 in done cycle, lo=0x2A, hi=0; second start not executed.
- Reset asserted asynchronously (between edges) at iteration 20 of DIVU -> hi=lo=0, busy=0 before next edge; no done pulse after release.
- (MULDIV_SIGNED_EN) MULT -6*7 -> done after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
